// File: rtl/sobel_pkg.sv
// Shared types and constants for the pixel window controller.
// Line width default, buffer count, window width, FSM encoding.
package sobel_pkg;

  localparam int LINE_W_DEF = 1280;
  localparam int NUM_LB     = 4;
  localparam int WIN_W      = 72;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_t;

  // Read strobe mask: three buffers starting at sel, wrapping mod 4.
  function automatic logic [NUM_LB-1:0] rot3(input logic [1:0] sel);
    logic [2*NUM_LB-1:0] t;
    t = {4'b0111, 4'b0111} << sel;
    return t[2*NUM_LB-1:NUM_LB];
  endfunction

endpackage

// File: rtl/pixel_window_ctrl_if.sv
// Pixel stream / line buffer / window bundle.
// master = pixel source + buffers, slave = controller.
interface pixel_window_ctrl_if;
  import sobel_pkg::*;

  logic              pixel_valid_in;
  logic [7:0]        pixel_in;
  logic [NUM_LB-1:0] lb_wr_valid;
  logic [7:0]        lb_wr_data;
  logic [NUM_LB-1:0] lb_rd;
  logic [23:0]       lb_data0;
  logic [23:0]       lb_data1;
  logic [23:0]       lb_data2;
  logic [23:0]       lb_data3;
  logic [WIN_W-1:0]  window_out;
  logic              window_valid;
  logic              line_done_intr;
  logic              ovf_err;

  modport master (
    output pixel_valid_in, pixel_in,
    output lb_data0, lb_data1, lb_data2, lb_data3,
    input  lb_wr_valid, lb_wr_data, lb_rd,
    input  window_out, window_valid,
    input  line_done_intr, ovf_err
  );

  modport slave (
    input  pixel_valid_in, pixel_in,
    input  lb_data0, lb_data1, lb_data2, lb_data3,
    output lb_wr_valid, lb_wr_data, lb_rd,
    output window_out, window_valid,
    output line_done_intr, ovf_err
  );

endinterface

// File: rtl/lb_rot_mux.sv
// Rotating 4-to-3 row select: rows sel, sel+1, sel+2 (mod 4).
// i_sel, i_d0..i_d3 in; o_win = {top, mid, bottom} out.
module lb_rot_mux
  import sobel_pkg::*;
(
  input  logic [1:0]       i_sel,
  input  logic [23:0]      i_d0,
  input  logic [23:0]      i_d1,
  input  logic [23:0]      i_d2,
  input  logic [23:0]      i_d3,
  output logic [WIN_W-1:0] o_win
);

  logic [23:0] w_d [NUM_LB];

  assign w_d[0] = i_d0;
  assign w_d[1] = i_d1;
  assign w_d[2] = i_d2;
  assign w_d[3] = i_d3;

  // 2-bit index arithmetic wraps mod 4 by itself.
  assign o_win = {w_d[i_sel],
                  w_d[i_sel + 2'd1],
                  w_d[i_sel + 2'd2]};

endmodule

// File: rtl/pixel_window_ctrl.sv
// 3x3 window controller over four rotating line buffers.
// clk, rst_n plain; pixel in, buffer strobes, window out on bus.
module pixel_window_ctrl
  import sobel_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  pixel_window_ctrl_if.slave bus
);

  localparam int CW = $clog2(LINE_W);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [12:0] FILL_RD  = 13'(3 * LINE_W);
  localparam logic [12:0] FILL_MAX = 13'(4 * LINE_W);

  state_t      r_state;
  logic [CW-1:0] r_wr_cnt;
  logic [CW-1:0] r_rd_cnt;
  logic [1:0]  r_wr_sel;
  logic [1:0]  r_rd_sel;
  logic [12:0] r_fill;
  logic        r_ovf;
  logic        r_line_done;

  logic w_rd;
  logic w_drop;
  logic w_wr;

  assign w_rd   = (r_state == ST_READ);
  // Full with no read this cycle: pixel has nowhere to go.
  assign w_drop = bus.pixel_valid_in
               && (r_fill == FILL_MAX) && !w_rd;
  assign w_wr   = bus.pixel_valid_in && !w_drop;

  assign bus.lb_wr_valid = (w_wr && rst_n)
                         ? (4'b0001 << r_wr_sel) : '0;
  assign bus.lb_wr_data  = bus.pixel_in;
  assign bus.lb_rd       = w_rd ? rot3(r_rd_sel) : '0;
  assign bus.window_valid   = w_rd;
  assign bus.line_done_intr = r_line_done;
  assign bus.ovf_err        = r_ovf;

  lb_rot_mux u_mux (
    .i_sel (r_rd_sel),
    .i_d0  (bus.lb_data0),
    .i_d1  (bus.lb_data1),
    .i_d2  (bus.lb_data2),
    .i_d3  (bus.lb_data3),
    .o_win (bus.window_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_wr_sel <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_drop) r_ovf <= 1'b1;
      if (w_wr) begin
        if (r_wr_cnt == COL_LAST) begin
          r_wr_cnt <= '0;
          r_wr_sel <= r_wr_sel + 2'd1;
        end else begin
          r_wr_cnt <= r_wr_cnt + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill <= '0;
    end else begin
      unique case (1'b1)
        w_wr && !w_rd: r_fill <= r_fill + 13'd1;
        w_rd && !w_wr: r_fill <= r_fill - 13'd1;
        default:       r_fill <= r_fill;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_rd_cnt    <= '0;
      r_rd_sel    <= '0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (r_fill >= FILL_RD) r_state <= ST_READ;
        end
        ST_READ: begin
          if (r_rd_cnt == COL_LAST) begin
            r_state     <= ST_IDLE;
            r_rd_cnt    <= '0;
            r_rd_sel    <= r_rd_sel + 2'd1;
            r_line_done <= 1'b1;
          end else begin
            r_rd_cnt <= r_rd_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_window_ctrl.sv
// Directed bench for pixel_window_ctrl at LINE_W = 8.
// Drives bus after posedge, checks at negedge.
module tb_pixel_window_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   fill_m;
  int   fill_max;

  pixel_window_ctrl_if bus ();

  pixel_window_ctrl #(.LINE_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] p);
    @(posedge clk);
    #1;
    bus.pixel_valid_in = v;
    bus.pixel_in       = p;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_ovf", bus.ovf_err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.pixel_valid_in = 1'b1;
    bus.pixel_in = 8'h55;
    bus.lb_data0 = 24'h010203;
    bus.lb_data1 = 24'h111213;
    bus.lb_data2 = 24'h212223;
    bus.lb_data3 = 24'h313233;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_wr_valid", bus.lb_wr_valid, 4'b0000);
    chk("rst_lb_rd", bus.lb_rd, 4'b0000);
    chk("rst_win_valid", bus.window_valid, 1'b0);
    chk("rst_line_done", bus.line_done_intr, 1'b0);
    chk("rst_window", bus.window_out,
        72'h010203_111213_212223);
    bus.pixel_valid_in = 1'b0;
    rst_n = 1'b1;

    // Fill three lines
    for (int i = 0; i < 24; i++) begin
      cyc(1'b1, 8'(i));
      chk("wr_strobe", bus.lb_wr_valid, 4'b0001 << (i / 8));
      if (i % 8 == 3)
        chk("wr_data", bus.lb_wr_data, 72'(i));
    end
    cyc(1'b0, 8'h00);
    chk("rd_wait", bus.lb_rd, 4'b0000);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 8'h00);
      chk("rd_line0", bus.lb_rd, 4'b0111);
      if (i == 0 || i == 7)
        chk("win_valid0", bus.window_valid, 1'b1);
    end
    cyc(1'b0, 8'h00);
    chk("line_done", bus.line_done_intr, 1'b1);
    chk("idle_rd", bus.lb_rd, 4'b0000);
    chk("idle_wv", bus.window_valid, 1'b0);
    cyc(1'b0, 8'h00);
    chk("line_done_pulse", bus.line_done_intr, 1'b0);

    // Refill into buffer 3, next line reads 1,2,3
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 8'hA0 + 8'(i));
      chk("wr_buf3", bus.lb_wr_valid, 4'b1000);
    end
    cyc(1'b0, 8'h00);
    chk("rd_wait1", bus.lb_rd, 4'b0000);
    bus.lb_data0 = 24'h0A0B0C;
    cyc(1'b0, 8'h00);
    chk("rd_line1", bus.lb_rd, 4'b1110);
    chk("window_l1", bus.window_out,
        72'h111213_212223_313233);

    // Continuous stream until overflow
    do_reset();
    fill_m = 0;
    fill_max = 0;
    for (int c = 0; c < 100; c++) begin
      cyc(1'b1, 8'(c));
      if (bus.lb_wr_valid != 4'b0000) fill_m++;
      if (bus.lb_rd != 4'b0000) fill_m--;
      if (fill_m > fill_max) fill_max = fill_m;
      if (c == 32) chk("fill_hold", 72'(fill_m), 72'd25);
      if (c == 39) chk("ovf_40px", bus.ovf_err, 1'b0);
      if (c == 95) begin
        chk("wr_full_rd", 72'(bus.lb_wr_valid != 4'b0000), 72'd1);
        chk("ovf_pre", bus.ovf_err, 1'b0);
      end
      if (c == 96) begin
        chk("drop_strobe", bus.lb_wr_valid, 4'b0000);
        chk("drop_ovf0", bus.ovf_err, 1'b0);
        chk("fill_full", 72'(fill_m), 72'd32);
      end
      if (c == 97) chk("ovf_set", bus.ovf_err, 1'b1);
    end
    chk("fill_max", 72'(fill_max), 72'd32);
    repeat (3) cyc(1'b0, 8'h00);
    chk("ovf_sticky", bus.ovf_err, 1'b1);

    // Reset mid-line at wr_cnt=5, rd_cnt=3
    do_reset();
    for (int c = 0; c < 38; c++) cyc(1'b1, 8'(c));
    chk("mid_rd", bus.lb_rd, 4'b1110);
    rst_n = 1'b0;
    #1;
    chk("async_wr", bus.lb_wr_valid, 4'b0000);
    chk("async_rd", bus.lb_rd, 4'b0000);
    chk("async_wv", bus.window_valid, 1'b0);
    chk("async_ld", bus.line_done_intr, 1'b0);
    chk("async_win", bus.window_out,
        72'h0A0B0C_111213_212223);
    @(negedge clk);
    bus.pixel_valid_in = 1'b0;
    rst_n = 1'b1;
    cyc(1'b1, 8'h77);
    chk("post_rst_wr", bus.lb_wr_valid, 4'b0001);
    cyc(1'b1, 8'h78);
    chk("post_rst_wr2", bus.lb_wr_valid, 4'b0001);
    chk("post_rst_rd", bus.lb_rd, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
